// File: rtl/match_clear_ctrl_if.sv
// Bus between the pair sequencer and the 16x16 card-clear pixel stage.
// The sequencer is the master: it supplies the card origin and the enable.
interface match_clear_ctrl_if;
    logic [7:0] x0;
    logic [6:0] y0;
    logic       clear_en;
    logic       clear_done;

    modport master (output x0, y0, clear_en, input  clear_done);
    modport slave  (input  x0, y0, clear_en, output clear_done);
endinterface

// File: rtl/match_clear_ctrl.sv
// Sequencer that clears a matched pair of cards, one card at a time, via the clear stage.
// Optional per-card watchdog enabled by defining CLEAR_TIMEOUT_EN.
module match_clear_ctrl #(
    parameter int unsigned X_ORIGIN    = 8,
    parameter int unsigned Y_ORIGIN    = 8,
    parameter int unsigned PITCH_X     = 20,
    parameter int unsigned PITCH_Y     = 20,
    parameter int unsigned MASK_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 2
`ifdef CLEAR_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT     = 1024
`endif
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [3:0]          card_a,
    input  logic [3:0]          card_b,
    input  logic                new_game,
    match_clear_ctrl_if.master  clr,
    output logic                busy,
    output logic                done,
    output logic [15:0]         cleared_mask,
    output logic                timeout_err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD_A  = 3'd1;
    localparam logic [2:0] S_CLEAR_A = 3'd2;
    localparam logic [2:0] S_GAP     = 3'd3;
    localparam logic [2:0] S_LOAD_B  = 3'd4;
    localparam logic [2:0] S_CLEAR_B = 3'd5;
    localparam logic [2:0] S_FINISH  = 3'd6;

    localparam int MW = (MASK_CYCLES > 0) ? $clog2(MASK_CYCLES + 1) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    logic [2:0]    state;
    logic [3:0]    cap_a;
    logic [3:0]    cap_b;
    logic [MW-1:0] mask_cnt;
    logic [GW-1:0] gap_cnt;
    logic          in_clear;
    logic          clear_ok;
    logic          timed_out;
    logic [3:0]    cur_card;

    function automatic logic [7:0] origin_x(input logic [1:0] col);
        return 8'(X_ORIGIN + 32'(col) * PITCH_X);
    endfunction

    function automatic logic [6:0] origin_y(input logic [1:0] row);
        return 7'(Y_ORIGIN + 32'(row) * PITCH_Y);
    endfunction

    assign in_clear     = (state == S_CLEAR_A) || (state == S_CLEAR_B);
    assign clr.clear_en = in_clear;
    assign busy         = (state != S_IDLE);
    assign done         = (state == S_FINISH);
    assign cur_card     = (state == S_CLEAR_B) ? cap_b : cap_a;
    // A stale clear_done from the previous card is ignored until the mask window has elapsed.
    assign clear_ok     = in_clear && (mask_cnt == MW'(MASK_CYCLES)) && clr.clear_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_cnt <= '0;
        end else if (!in_clear) begin
            mask_cnt <= '0;
        end else if (mask_cnt != MW'(MASK_CYCLES)) begin
            mask_cnt <= mask_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gap_cnt <= '0;
        end else if (state != S_GAP) begin
            gap_cnt <= '0;
        end else begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end

`ifdef CLEAR_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);

    logic [WW-1:0] wd_cnt;

    assign timed_out = in_clear && (wd_cnt == WW'(TIMEOUT - 1)) && !clear_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (!in_clear) begin
                wd_cnt <= '0;
            end else if (wd_cnt != WW'(TIMEOUT - 1)) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (timed_out) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign timed_out   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            cap_a        <= '0;
            cap_b        <= '0;
            clr.x0       <= '0;
            clr.y0       <= '0;
            cleared_mask <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cap_a <= card_a;
                        cap_b <= card_b;
                        state <= S_LOAD_A;
                    end else if (new_game) begin
                        cleared_mask <= '0;
                    end
                end
                S_LOAD_A: begin
                    clr.x0 <= origin_x(cap_a[1:0]);
                    clr.y0 <= origin_y(cap_a[3:2]);
                    state  <= cleared_mask[cap_a] ? S_GAP : S_CLEAR_A;
                end
                S_CLEAR_A, S_CLEAR_B: begin
                    // A watchdog expiry advances the sequence but leaves the card uncleared.
                    if (clear_ok || timed_out) begin
                        if (clear_ok) begin
                            cleared_mask[cur_card] <= 1'b1;
                        end
                        state <= (state == S_CLEAR_A) ? S_GAP : S_FINISH;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                        state <= S_LOAD_B;
                    end
                end
                S_LOAD_B: begin
                    clr.x0 <= origin_x(cap_b[1:0]);
                    clr.y0 <= origin_y(cap_b[3:2]);
                    state  <= (cleared_mask[cap_b] || (cap_b == cap_a)) ? S_FINISH : S_CLEAR_B;
                end
                S_FINISH: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_match_clear_ctrl.sv
// Scoreboard bench for match_clear_ctrl: expected clear windows and done results are queued
// at stimulus time and consumed as the DUT opens windows and pulses done.
module tb_match_clear_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        new_game = 1'b0;
    logic [3:0]  card_a = '0;
    logic [3:0]  card_b = '0;
    logic        busy;
    logic        done;
    logic        timeout_err;
    logic [15:0] cleared_mask;

    match_clear_ctrl_if clr_if();

    match_clear_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .card_a       (card_a),
        .card_b       (card_b),
        .new_game     (new_game),
        .clr          (clr_if),
        .busy         (busy),
        .done         (done),
        .cleared_mask (cleared_mask),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
    } win_t;

    typedef struct {
        logic [15:0] mask;
        int          lat;
    } done_t;

    win_t        exp_win_q[$];
    done_t       exp_done_q[$];
    int          win_len_q[$];
    int          low_len_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          done_cnt = 0;
    int          win_cnt = 0;
    int          resp_mode = 0;
    int          resp_delay = 10;
    logic [15:0] m_mask = '0;
    win_t        cur_win;
    win_t        mon_w;
    done_t       mon_d;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Card origin on the 4x4 board: 8 + 20*col, 8 + 20*row.
    function automatic win_t win_of(input logic [3:0] idx);
        win_t w;
        w.x = 8'(8 + 20 * int'(idx[1:0]));
        w.y = 7'(8 + 20 * int'(idx[3:2]));
        return w;
    endfunction

    // Clear-stage model: 0 = done after resp_delay enabled cycles, 1 = always high, 2 = never.
    initial begin
        int en_cnt;
        en_cnt = 0;
        clr_if.clear_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (clr_if.clear_en) en_cnt++;
            else en_cnt = 0;
            case (resp_mode)
                0:       clr_if.clear_done = clr_if.clear_en && (en_cnt >= resp_delay);
                1:       clr_if.clear_done = 1'b1;
                default: clr_if.clear_done = 1'b0;
            endcase
        end
    end

    initial begin
        logic prev_en;
        logic prev_done;
        int   en_len;
        int   low_len;
        prev_en = 1'b0;
        prev_done = 1'b0;
        en_len = 0;
        low_len = 0;
        cur_win = '{x: '0, y: '0};
        forever begin
            @(negedge clk);
            if (prev_done) checkOutput("done_one_cycle", done, 0);
            if (done) begin
                done_cnt++;
                checkOutput("done_expected", exp_done_q.size() != 0, 1);
                if (exp_done_q.size() != 0) begin
                    mon_d = exp_done_q.pop_front();
                    checkOutput("mask_at_done", cleared_mask, mon_d.mask);
                    if (mon_d.lat >= 0) checkOutput("done_latency", cyc - start_cyc, mon_d.lat);
                end
            end
            if (clr_if.clear_en && !prev_en) begin
                win_cnt++;
                low_len_q.push_back(low_len);
                en_len = 1;
                checkOutput("window_expected", exp_win_q.size() != 0, 1);
                if (exp_win_q.size() != 0) begin
                    mon_w = exp_win_q.pop_front();
                    cur_win = mon_w;
                    checkOutput("x0_window", clr_if.x0, mon_w.x);
                    checkOutput("y0_window", clr_if.y0, mon_w.y);
                end
            end else if (clr_if.clear_en) begin
                en_len++;
            end else if (prev_en) begin
                win_len_q.push_back(en_len);
                low_len = 1;
                if (reset_n) begin
                    checkOutput("x0_stable", clr_if.x0, cur_win.x);
                    checkOutput("y0_stable", clr_if.y0, cur_win.y);
                end
            end else begin
                low_len++;
            end
            prev_en = clr_if.clear_en;
            prev_done = done;
        end
    end

    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input int lat);
        int target;
        if (!m_mask[a]) begin
            exp_win_q.push_back(win_of(a));
            if (resp_mode != 2) m_mask[a] = 1'b1;
        end
        if ((b != a) && !m_mask[b]) begin
            exp_win_q.push_back(win_of(b));
            if (resp_mode != 2) m_mask[b] = 1'b1;
        end
        exp_done_q.push_back('{mask: m_mask, lat: lat});
        target = done_cnt + 1;
        @(negedge clk);
        card_a = a;
        card_b = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start = 1'b0;
        card_a = ~a;
        card_b = ~b;
        checkOutput("busy_after_start", busy, 1);
        // A second request while busy must not restart or open extra windows.
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3000 && done_cnt < target; i++) @(negedge clk);
        checkOutput("done_wait", done_cnt, target);
        @(negedge clk);
        checkOutput("busy_idle", busy, 0);
        checkOutput("windows_left", exp_win_q.size(), 0);
    endtask

    task automatic pulseNewGame();
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        m_mask = '0;
        checkOutput("mask_new_game", cleared_mask, 16'h0000);
    endtask

    initial begin
        int base;
        repeat (3) @(negedge clk);
        checkOutput("rst_x0", clr_if.x0, 0);
        checkOutput("rst_y0", clr_if.y0, 0);
        checkOutput("rst_clear_en", clr_if.clear_en, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_mask", cleared_mask, 0);
        checkOutput("rst_timeout_err", timeout_err, 0);
        reset_n = 1'b1;
        @(negedge clk);

        resp_mode = 0;
        resp_delay = 10;
        applyStimulus(4'd5, 4'd15, -1);
        checkOutput("mask_pair_5_15", cleared_mask, 16'h8020);

        // Both already cleared: LOAD_A, GAP x2, LOAD_B, then done in the fifth cycle after start.
        applyStimulus(4'd5, 4'd15, 4);
        checkOutput("mask_skip", cleared_mask, 16'h8020);

        pulseNewGame();
        applyStimulus(4'd3, 4'd3, -1);
        checkOutput("mask_pair_3_3", cleared_mask, 16'h0008);

        // Flag stuck high: each window lasts MASK_CYCLES+1; enable is low for GAP plus LOAD_B.
        resp_mode = 1;
        clr_if.clear_done = 1'b1;
        repeat (2) @(negedge clk);
        win_len_q.delete();
        low_len_q.delete();
        applyStimulus(4'd0, 4'd1, 14);
        checkOutput("win_count", win_len_q.size(), 2);
        if (win_len_q.size() == 2) begin
            checkOutput("win_len_a", win_len_q[0], 5);
            checkOutput("win_len_b", win_len_q[1], 5);
        end
        if (low_len_q.size() == 2) checkOutput("gap_low_len", low_len_q[1], 3);
        checkOutput("mask_pair_0_1", cleared_mask, 16'h000B);

        resp_mode = 0;
        base = win_cnt;
        exp_win_q.push_back(win_of(4'd2));
        exp_win_q.push_back(win_of(4'd6));
        @(negedge clk);
        card_a = 4'd2;
        card_b = 4'd6;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200 && win_cnt < base + 2; i++) @(negedge clk);
        checkOutput("clear_b_reached", win_cnt, base + 2);
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_x0", clr_if.x0, 0);
        checkOutput("async_y0", clr_if.y0, 0);
        checkOutput("async_clear_en", clr_if.clear_en, 0);
        checkOutput("async_busy", busy, 0);
        checkOutput("async_done", done, 0);
        checkOutput("async_mask", cleared_mask, 0);
        checkOutput("async_timeout_err", timeout_err, 0);
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        m_mask = '0;
        checkOutput("windows_after_reset", exp_win_q.size(), 0);
        applyStimulus(4'd9, 4'd9, -1);
        checkOutput("mask_after_reset", cleared_mask, 16'h0200);

`ifdef CLEAR_TIMEOUT_EN
        pulseNewGame();
        resp_mode = 2;
        win_len_q.delete();
        // 1024 cycles in CLEAR_A after LOAD_A, then GAP x2, LOAD_B (skipped as duplicate), FINISH.
        applyStimulus(4'd4, 4'd4, 1028);
        checkOutput("timeout_err_set", timeout_err, 1);
        checkOutput("mask_timeout", cleared_mask, 16'h0000);
        if (win_len_q.size() != 0) checkOutput("timeout_win_len", win_len_q[0], 1024);
`else
        checkOutput("timeout_err_tied", timeout_err, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
